frame_buffer_arbiter: RTL and testbench
=======================================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BURST_LEN, 256: 16-bit words per SDRAM burst.
- FRAME_WORDS, 307200: words per frame (640x480); a multiple of BURST_LEN.
- FIFO_DEPTH, 1024: depth of each async FIFO.
- RD_LOW, 128: VGA FIFO urgent watermark.
- ADDR_W, 24: SDRAM word address width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock, same domain as the SDRAM controller.
- rst, in, 1: synchronous, active-high reset.
- cam_fifo_count, in, 10: camera FIFO read-side occupancy.
- cam_frame_start, in, 1: 1-cycle pulse, start of camera frame.
- vga_fifo_count, in, 10: VGA FIFO write-side occupancy.
- vga_frame_start, in, 1: 1-cycle pulse, start of VGA frame.
- cmd_ready, in, 1: SDRAM controller accepts a command.
- burst_done, in, 1: 1-cycle pulse, current burst complete.
- cmd_valid, out, 1: command request.
- cmd_write, out, 1: 1 = camera-to-SDRAM write, 0 = SDRAM-to-VGA read.
- cmd_addr, out, ADDR_W: burst start address.
- cmd_len, out, 9: equals BURST_LEN.
- wr_active, out, 1: write burst in progress.
- rd_active, out, 1: read burst in progress.
- cam_overflow, out, 1: sticky camera FIFO overflow flag.

REQ-003 Clock and reset SHALL be exactly as decided: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The state machine SHALL have states IDLE, WR_REQ, WR_BURST, RD_REQ and RD_BURST.

REQ-005 Eligibility SHALL be defined as:
- wr_elig = cam_fifo_count >= BURST_LEN.
- rd_elig = vga_fifo_count <= FIFO_DEPTH-BURST_LEN.
- rd_urgent = vga_fifo_count < RD_LOW.

REQ-006 In IDLE, after any pending frame-start updates (REQ-012), the state SHALL go to the first matching case below, else stay in IDLE:
- rd_urgent: go to RD_REQ.
- wr_elig and rd_elig both true: go to the class opposite last_grant (round-robin).
- wr_elig only: go to WR_REQ.
- rd_elig only: go to RD_REQ.

REQ-007 last_grant SHALL update on each transition into WR_BURST or RD_BURST, and SHALL reset to read.

REQ-008 In WR_REQ/RD_REQ, cmd_valid SHALL be 1, and cmd_write/cmd_addr SHALL be stable until the first cycle with cmd_ready=1; that cycle moves to WR_BURST/RD_BURST. cmd_valid SHALL be 0 in all other states.

REQ-009 Eligibility SHALL be registered in IDLE, so cmd_valid asserts exactly 1 cycle after the cycle eligibility is sampled.

REQ-010 In WR_BURST/RD_BURST, the machine SHALL wait for burst_done, then return to IDLE on the next edge. On that edge, the relevant offset SHALL advance by BURST_LEN and wrap to 0 when it reaches FRAME_WORDS. burst_done in any other state SHALL be ignored.

REQ-011 Addressing SHALL be double-buffered:
- Write address: cmd_addr = {wr_bank, wr_offset[ADDR_W-2:0]}.
- Read address: cmd_addr = {rd_bank, rd_offset[ADDR_W-2:0]}.
- Reset values: wr_bank=0, rd_bank=1, avail_bank=1.

REQ-012 Frame-start handling:
- cam_frame_start and vga_frame_start SHALL set pending flags wr_sof and rd_sof.
- Pending flags SHALL be applied only in IDLE, never mid-burst.
- Applying wr_sof: wr_offset<=0 and wr_bank toggles. If the previous frame reached FRAME_WORDS (wr_full flag), avail_bank<=old wr_bank. wr_full clears.
- Applying rd_sof: rd_offset<=0 and rd_bank<=avail_bank.
- If both are pending, both apply in the same cycle, and rd_bank takes the newly updated avail_bank.
- A pulse arriving while its flag is already set SHALL be absorbed.

REQ-013 wr_full SHALL set when wr_offset wraps. Further write bursts in the same frame SHALL rewrite the same bank from offset 0.

REQ-014 cam_overflow SHALL set when cam_fifo_count >= FIFO_DEPTH-1, and SHALL stay set until rst.

REQ-015 wr_active SHALL be 1 only in WR_BURST, and rd_active SHALL be 1 only in RD_BURST.

REQ-016 cmd_len SHALL be the constant BURST_LEN.

Reset
REQ-017 While rst=1 at a clk edge:
- State SHALL go to IDLE.
- All outputs SHALL be 0, except cmd_len=BURST_LEN and cmd_addr=0.
- Offsets SHALL be 0; pending flags, wr_full and cam_overflow SHALL be cleared.

REQ-018 rst asserted mid-burst SHALL abort to IDLE on the next edge with no address advance. A burst_done arriving after reset SHALL be ignored.

Verification
REQ-019 Simple write: cam_fifo_count=256, vga_fifo_count=900, cmd_ready=1 -> cmd_valid=1 one cycle later, cmd_write=1, cmd_addr=0x000000. After burst_done, the next write uses 0x000100.

REQ-020 Urgent read priority: cam_fifo_count=600, vga_fifo_count=100 -> read is granted first (cmd_write=0, cmd_addr=0x800000) despite the pending write.

REQ-021 Round-robin: cam_fifo_count=300 and vga_fifo_count=500 held constant, burst_done after each grant -> grants alternate W,R,W,R (first W, since last_grant resets to read).

REQ-022 Frame wrap and bank swap:
- Write 1200 bursts, then pulse cam_frame_start mid-burst -> the swap is deferred until IDLE; next write addr=0x800000.
- Then vga_frame_start -> next read addr=0x000000.

REQ-023 Handshake hold: cmd_ready=0 for 5 cycles in WR_REQ -> cmd_valid, cmd_write and cmd_addr are stable all 5 cycles; WR_BURST is entered on the cycle after cmd_ready=1.

REQ-024 Overflow and reset: cam_fifo_count=1023 -> cam_overflow=1 and stays 1. Then rst=1 during RD_BURST -> next edge gives IDLE, cam_overflow=0, rd_offset unchanged at 0.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one SDRAM controller between a camera write
// stream and a VGA read stream. Bursts are granted by FIFO occupancy, with
// urgent reads first and round-robin otherwise. The two frame banks are
// swapped only between bursts, so a frame in progress never changes bank.
module frame_buffer_arbiter #(
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int FIFO_DEPTH  = 1024,
    parameter int RD_LOW      = 128,
    parameter int ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        cam_fifo_count,
    input  logic              cam_frame_start,
    input  logic [9:0]        vga_fifo_count,
    input  logic              vga_frame_start,
    input  logic              cmd_ready,
    input  logic              burst_done,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [8:0]        cmd_len,
    output logic              wr_active,
    output logic              rd_active,
    output logic              cam_overflow
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BURST,
        RD_REQ,
        RD_BURST
    } state_t;

    // Occupancy thresholds, sized to the FIFO count ports.
    localparam logic [9:0] WR_LVL  = 10'(BURST_LEN);
    localparam logic [9:0] RD_LVL  = 10'(FIFO_DEPTH - BURST_LEN);
    localparam logic [9:0] URG_LVL = 10'(RD_LOW);
    localparam logic [9:0] OVF_LVL = 10'(FIFO_DEPTH - 1);

    // Offset step and the last burst offset before the frame wraps.
    localparam logic [ADDR_W-2:0] OFF_STEP = (ADDR_W-1)'(BURST_LEN);
    localparam logic [ADDR_W-2:0] OFF_LAST = (ADDR_W-1)'(FRAME_WORDS - BURST_LEN);

    state_t            state;
    state_t            state_next;
    logic              last_grant_wr;
    logic [ADDR_W-2:0] wr_offset;
    logic [ADDR_W-2:0] rd_offset;
    logic              wr_bank;
    logic              rd_bank;
    logic              avail_bank;
    logic              wr_full;
    logic              wr_sof;
    logic              rd_sof;

    logic wr_elig;
    logic rd_elig;
    logic rd_urgent;
    logic wr_sof_now;
    logic rd_sof_now;
    logic avail_next;

    assign wr_elig   = cam_fifo_count >= WR_LVL;
    assign rd_elig   = vga_fifo_count <= RD_LVL;
    assign rd_urgent = vga_fifo_count <  URG_LVL;
    assign cmd_len   = 9'(BURST_LEN);

    // A frame start arriving in the same idle cycle is applied immediately
    // together with any already-pending one.
    assign wr_sof_now = wr_sof | cam_frame_start;
    assign rd_sof_now = rd_sof | vga_frame_start;

    // The read side must see the bank the camera just finished, even when
    // both frame starts are applied in the same cycle.
    assign avail_next = (wr_sof_now && wr_full) ? wr_bank : avail_bank;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and command outputs.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        wr_active  = 1'b0;
        rd_active  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_urgent)              state_next = RD_REQ;
                else if (wr_elig && rd_elig) state_next = last_grant_wr ? RD_REQ : WR_REQ;
                else if (wr_elig)           state_next = WR_REQ;
                else if (rd_elig)           state_next = RD_REQ;
            end
            WR_REQ: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = {wr_bank, wr_offset};
                if (cmd_ready) state_next = WR_BURST;
            end
            WR_BURST: begin
                cmd_write = 1'b1;
                cmd_addr  = {wr_bank, wr_offset};
                wr_active = 1'b1;
                if (burst_done) state_next = IDLE;
            end
            RD_REQ: begin
                cmd_valid = 1'b1;
                cmd_addr  = {rd_bank, rd_offset};
                if (cmd_ready) state_next = RD_BURST;
            end
            RD_BURST: begin
                cmd_addr  = {rd_bank, rd_offset};
                rd_active = 1'b1;
                if (burst_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address bookkeeping: frame-start swaps in idle, offset advance at burst end.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_wr <= 1'b0;
            wr_offset     <= '0;
            rd_offset     <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
            avail_bank    <= 1'b1;
            wr_full       <= 1'b0;
            wr_sof        <= 1'b0;
            rd_sof        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_sof     <= 1'b0;
                    rd_sof     <= 1'b0;
                    avail_bank <= avail_next;
                    if (wr_sof_now) begin
                        wr_offset <= '0;
                        wr_bank   <= ~wr_bank;
                        wr_full   <= 1'b0;
                    end
                    if (rd_sof_now) begin
                        rd_offset <= '0;
                        rd_bank   <= avail_next;
                    end
                end
                WR_REQ: begin
                    wr_sof <= wr_sof_now;
                    rd_sof <= rd_sof_now;
                    if (cmd_ready) last_grant_wr <= 1'b1;
                end
                RD_REQ: begin
                    wr_sof <= wr_sof_now;
                    rd_sof <= rd_sof_now;
                    if (cmd_ready) last_grant_wr <= 1'b0;
                end
                WR_BURST: begin
                    wr_sof <= wr_sof_now;
                    rd_sof <= rd_sof_now;
                    if (burst_done) begin
                        // After a full frame, keep rewriting this bank from 0
                        // until the camera starts a new frame.
                        if (wr_offset == OFF_LAST) begin
                            wr_offset <= '0;
                            wr_full   <= 1'b1;
                        end else begin
                            wr_offset <= wr_offset + OFF_STEP;
                        end
                    end
                end
                RD_BURST: begin
                    wr_sof <= wr_sof_now;
                    rd_sof <= rd_sof_now;
                    if (burst_done) begin
                        if (rd_offset == OFF_LAST) rd_offset <= '0;
                        else                       rd_offset <= rd_offset + OFF_STEP;
                    end
                end
                default: begin
                    wr_sof <= wr_sof_now;
                    rd_sof <= rd_sof_now;
                end
            endcase
        end
    end

    // Sticky camera overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                            cam_overflow <= 1'b0;
        else if (cam_fifo_count >= OVF_LVL) cam_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter. A transaction-level model
// tracks grant order, bank selection and frame offsets; directed scenarios
// cover the documented cases and a random run covers mixed traffic.
module tb_frame_buffer_arbiter;

    localparam int BURST_LEN   = 256;
    localparam int FRAME_WORDS = 307200;
    localparam int FIFO_DEPTH  = 1024;
    localparam int RD_LOW      = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cam_fifo_count;
    logic        cam_frame_start;
    logic [9:0]  vga_fifo_count;
    logic        vga_frame_start;
    logic        cmd_ready;
    logic        burst_done;
    logic        cmd_valid;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        wr_active;
    logic        rd_active;
    logic        cam_overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_wr_off;
    int m_rd_off;
    bit m_wr_bank;
    bit m_rd_bank;
    bit m_avail;
    bit m_wr_full;
    bit m_last_wr;
    bit m_wr_sof;
    bit m_rd_sof;

    // Last observed grant.
    logic        obs_write;
    logic [23:0] obs_addr;

    frame_buffer_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .cam_fifo_count  (cam_fifo_count),
        .cam_frame_start (cam_frame_start),
        .vga_fifo_count  (vga_fifo_count),
        .vga_frame_start (vga_frame_start),
        .cmd_ready       (cmd_ready),
        .burst_done      (burst_done),
        .cmd_valid       (cmd_valid),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_active       (wr_active),
        .rd_active       (rd_active),
        .cam_overflow    (cam_overflow)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        m_wr_off  = 0;
        m_rd_off  = 0;
        m_wr_bank = 1'b0;
        m_rd_bank = 1'b1;
        m_avail   = 1'b1;
        m_wr_full = 1'b0;
        m_last_wr = 1'b0;
        m_wr_sof  = 1'b0;
        m_rd_sof  = 1'b0;
    endfunction

    // 0 = no grant, 1 = write, 2 = read.
    function automatic int predict(int cam, int vga);
        bit we  = cam >= BURST_LEN;
        bit re  = vga <= FIFO_DEPTH - BURST_LEN;
        bit urg = vga < RD_LOW;
        if (urg)      return 2;
        if (we && re) return m_last_wr ? 2 : 1;
        if (we)       return 1;
        if (re)       return 2;
        return 0;
    endfunction

    function automatic void model_apply_sof();
        if (m_wr_sof) begin
            if (m_wr_full) m_avail = m_wr_bank;
            m_wr_bank = !m_wr_bank;
            m_wr_off  = 0;
            m_wr_full = 1'b0;
        end
        if (m_rd_sof) begin
            m_rd_off  = 0;
            m_rd_bank = m_avail;
        end
        m_wr_sof = 1'b0;
        m_rd_sof = 1'b0;
    endfunction

    function automatic logic [23:0] m_addr(bit wr);
        bit b   = wr ? m_wr_bank : m_rd_bank;
        int off = wr ? m_wr_off : m_rd_off;
        return {b, 23'(off)};
    endfunction

    function automatic void model_burst_end(bit wr);
        if (wr) begin
            m_wr_off += BURST_LEN;
            if (m_wr_off == FRAME_WORDS) begin
                m_wr_off  = 0;
                m_wr_full = 1'b1;
            end
        end else begin
            m_rd_off += BURST_LEN;
            if (m_rd_off == FRAME_WORDS) m_rd_off = 0;
        end
    endfunction

    task automatic do_reset();
        rst             = 1'b1;
        cam_fifo_count  = 10'd0;
        vga_fifo_count  = 10'd900;
        cam_frame_start = 1'b0;
        vga_frame_start = 1'b0;
        cmd_ready       = 1'b0;
        burst_done      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One grant from an idle arbiter: drive occupancies, check the request,
    // hold it off for 'hold' cycles, accept it, pulse frame starts during the
    // burst, then finish the burst after 'dly' more cycles.
    task automatic run_grant(input int cam, input int vga, input int hold, input int dly,
                             input int cam_sof, input int vga_sof, input string tag);
        int          g;
        bit          ew;
        logic [23:0] ea;
        int          np;
        cam_fifo_count = 10'(cam);
        vga_fifo_count = 10'(vga);
        g = predict(cam, vga);
        model_apply_sof();
        if (g == 0) begin
            obs_write = 1'b0;
            obs_addr  = '0;
            repeat (2) begin
                @(negedge clk);
                total++;
                if (cmd_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle: cmd_valid=%b want 0", tag, cmd_valid);
                end
            end
            return;
        end
        ew = (g == 1);
        ea = m_addr(ew);
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b1 || cmd_write !== ew || cmd_addr !== ea) begin
            bad++;
            $display("FAIL %s request: valid=%b write=%b addr=%h want valid=1 write=%b addr=%h",
                     tag, cmd_valid, cmd_write, cmd_addr, ew, ea);
        end
        obs_write = cmd_write;
        obs_addr  = cmd_addr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (cmd_valid !== 1'b1 || cmd_write !== ew || cmd_addr !== ea) begin
                bad++;
                $display("FAIL %s hold%0d: valid=%b write=%b addr=%h want valid=1 write=%b addr=%h",
                         tag, i, cmd_valid, cmd_write, cmd_addr, ew, ea);
            end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        m_last_wr = ew;
        total++;
        if (cmd_valid !== 1'b0 || wr_active !== ew || rd_active !== !ew) begin
            bad++;
            $display("FAIL %s burst entry: valid=%b wr_active=%b rd_active=%b want 0 %b %b",
                     tag, cmd_valid, wr_active, rd_active, ew, !ew);
        end
        np = (cam_sof > vga_sof) ? cam_sof : vga_sof;
        if (cam_sof > 0) m_wr_sof = 1'b1;
        if (vga_sof > 0) m_rd_sof = 1'b1;
        for (int k = 0; k < np; k++) begin
            cam_frame_start = (k < cam_sof);
            vga_frame_start = (k < vga_sof);
            @(negedge clk);
            cam_frame_start = 1'b0;
            vga_frame_start = 1'b0;
            @(negedge clk);
        end
        repeat (dly) @(negedge clk);
        total++;
        if (wr_active !== ew || rd_active !== !ew) begin
            bad++;
            $display("FAIL %s burst held: wr_active=%b rd_active=%b want %b %b",
                     tag, wr_active, rd_active, ew, !ew);
        end
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        total++;
        if (wr_active !== 1'b0 || rd_active !== 1'b0 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s burst end: wr_active=%b rd_active=%b valid=%b want 0 0 0",
                     tag, wr_active, rd_active, cmd_valid);
        end
        model_burst_end(ew);
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        cam_fifo_count  = 10'd600;
        vga_fifo_count  = 10'd100;
        cam_frame_start = 1'b0;
        vga_frame_start = 1'b0;
        cmd_ready       = 1'b1;
        burst_done      = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 24'h0 ||
            wr_active !== 1'b0 || rd_active !== 1'b0 || cam_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset outputs: valid=%b write=%b addr=%h wa=%b ra=%b ovf=%b want all 0",
                     cmd_valid, cmd_write, cmd_addr, wr_active, rd_active, cam_overflow);
        end
        total++;
        if (cmd_len !== 9'd256) begin
            bad++;
            $display("FAIL reset cmd_len: got=%0d want=256", cmd_len);
        end
        do_reset();
    endtask

    task automatic test_simple_write();
        do_reset();
        run_grant(256, 900, 0, 2, 0, 0, "simple_write1");
        total++;
        if (obs_write !== 1'b1 || obs_addr !== 24'h000000) begin
            bad++;
            $display("FAIL simple_write first: write=%b addr=%h want 1 000000", obs_write, obs_addr);
        end
        run_grant(256, 900, 0, 1, 0, 0, "simple_write2");
        total++;
        if (obs_write !== 1'b1 || obs_addr !== 24'h000100) begin
            bad++;
            $display("FAIL simple_write second: write=%b addr=%h want 1 000100", obs_write, obs_addr);
        end
    endtask

    task automatic test_urgent_read();
        do_reset();
        run_grant(600, 100, 0, 1, 0, 0, "urgent_read");
        total++;
        if (obs_write !== 1'b0 || obs_addr !== 24'h800000) begin
            bad++;
            $display("FAIL urgent_read: write=%b addr=%h want 0 800000", obs_write, obs_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_grant(300, 500, 0, 1, 0, 0, "round_robin");
            seq[3-i] = obs_write;
        end
        total++;
        if (seq !== 4'b1010) begin
            bad++;
            $display("FAIL round_robin order: got=%b want=1010 (W,R,W,R)", seq);
        end
    endtask

    task automatic test_handshake_hold();
        do_reset();
        run_grant(256, 900, 5, 0, 0, 0, "handshake_hold");
    endtask

    task automatic test_frame_wrap();
        do_reset();
        for (int i = 0; i < FRAME_WORDS / BURST_LEN; i++)
            run_grant(300, 900, 0, 0, 0, 0, "frame_fill");
        // Frame full: the next burst rewrites bank 0 while the frame start
        // arrives mid-burst (twice, the second absorbed).
        run_grant(300, 900, 0, 1, 2, 0, "frame_rewrite");
        total++;
        if (obs_addr !== 24'h000000) begin
            bad++;
            $display("FAIL frame_rewrite addr: got=%h want=000000", obs_addr);
        end
        run_grant(300, 900, 0, 1, 0, 1, "frame_swap_write");
        total++;
        if (obs_addr !== 24'h800000) begin
            bad++;
            $display("FAIL frame_swap_write addr: got=%h want=800000", obs_addr);
        end
        run_grant(0, 100, 0, 1, 0, 0, "frame_swap_read");
        total++;
        if (obs_write !== 1'b0 || obs_addr !== 24'h000000) begin
            bad++;
            $display("FAIL frame_swap_read: write=%b addr=%h want 0 000000", obs_write, obs_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 150; n++) begin
            int cam;
            int vga;
            cam = int'($urandom_range(1022, 0));
            vga = int'($urandom_range(1023, 0));
            run_grant(cam, vga, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 1)) : 0,
                      ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 1)) : 0,
                      "random");
        end
        total++;
        if (cam_overflow !== 1'b0) begin
            bad++;
            $display("FAIL random overflow: got=%b want=0", cam_overflow);
        end
    endtask

    task automatic test_overflow_reset();
        do_reset();
        cam_fifo_count = 10'd1023;
        vga_fifo_count = 10'd100;
        @(negedge clk);
        total++;
        if (cam_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow set: got=%b want=1", cam_overflow);
        end
        total++;
        if (cmd_valid !== 1'b1 || cmd_write !== 1'b0 || cmd_addr !== 24'h800000) begin
            bad++;
            $display("FAIL overflow read req: valid=%b write=%b addr=%h want 1 0 800000",
                     cmd_valid, cmd_write, cmd_addr);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready      = 1'b0;
        cam_fifo_count = 10'd0;
        vga_fifo_count = 10'd900;
        total++;
        if (rd_active !== 1'b1) begin
            bad++;
            $display("FAIL overflow rd_active: got=%b want=1", rd_active);
        end
        @(negedge clk);
        total++;
        if (cam_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow sticky: got=%b want=1", cam_overflow);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (rd_active !== 1'b0 || cmd_valid !== 1'b0 || cam_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset mid-burst: ra=%b valid=%b ovf=%b want 0 0 0",
                     rd_active, cmd_valid, cam_overflow);
        end
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        total++;
        if (rd_active !== 1'b0 || wr_active !== 1'b0 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray burst_done: ra=%b wa=%b valid=%b want 0 0 0",
                     rd_active, wr_active, cmd_valid);
        end
        run_grant(0, 100, 0, 1, 0, 0, "post_reset_read");
        total++;
        if (obs_addr !== 24'h800000) begin
            bad++;
            $display("FAIL post_reset_read addr: got=%h want=800000", obs_addr);
        end
    endtask

    initial begin
        test_reset();
        test_simple_write();
        test_urgent_read();
        test_round_robin();
        test_handshake_hold();
        test_frame_wrap();
        test_random();
        test_overflow_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
